matmul_operand_loader: RTL and testbench

- Upstream feeder for the 2x2 matrix multiplier.
- Accepts operand elements one word at a time over a valid/ready stream and assembles the X and Y matrices.
- Holds both matrices stable on the multiplier inputs, controls the multiplier's active-high rst/done sequence, and presents a result-ready handshake to the consumer.
- Sits between the host/DMA word stream and the multiplier.

---
 rtl/matmul_pkg.sv | 17 +
 rtl/matmul_operand_loader.sv | 144 ++++++++++++++
 tb/tb_matmul_operand_loader.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/matmul_pkg.sv
// Shared types for the 2x2 matrix multiplier datapath: element and matrix
// types plus the operand loader's state encoding.
package matmul_pkg;

    localparam int MAT_DIM = 2;
    localparam int ELEM_W  = 32;

    typedef logic [ELEM_W-1:0] elem_t;
    typedef elem_t [0:MAT_DIM-1][0:MAT_DIM-1] mat_t;

    typedef enum logic [1:0] {
        LOAD,
        RUN,
        RESULT
    } loader_state_e;

endpackage

// File: rtl/matmul_operand_loader.sv
// Operand loader for the 2x2 matrix multiplier.
// Collects eight words (X row-major, then Y row-major) from a valid/ready
// stream, holds them on the multiplier inputs, sequences the multiplier's
// active-high rst/done handshake and offers the result to the consumer.
// Optional build macro: MATMUL_LOADER_TIMEOUT_EN adds a RUN timeout that
// abandons the job and raises a sticky err flag.
module matmul_operand_loader
    import matmul_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic [DATA_W-1:0]                             in_data,
    input  logic                                          in_valid,
    output logic                                          in_ready,
    output logic [0:MAT_DIM-1][0:MAT_DIM-1][DATA_W-1:0]   x_out,
    output logic [0:MAT_DIM-1][0:MAT_DIM-1][DATA_W-1:0]   y_out,
    output logic                                          mul_rst,
    input  logic                                          mul_done,
    output logic                                          res_valid,
    input  logic                                          res_ready,
    output logic                                          busy,
    output logic                                          err
);

    loader_state_e state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [0:MAT_DIM-1][0:MAT_DIM-1][DATA_W-1:0] x_q, x_d;
    logic [0:MAT_DIM-1][0:MAT_DIM-1][DATA_W-1:0] y_q, y_d;
    // Low only during the first cycle after reset release so in_ready
    // comes up one cycle late.
    logic          armed_q, armed_d;
    logic          accept;

`ifdef MATMUL_LOADER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             err_q, err_d;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

    // Moore-style outputs decoded from the current state.
    always_comb begin
        in_ready  = (state_q == LOAD) && armed_q;
        mul_rst   = (state_q == LOAD);
        res_valid = (state_q == RESULT);
        busy      = !((state_q == LOAD) && (cnt_q == 3'd0));
        accept    = in_valid && in_ready;
    end

    // Next-state, slot capture and (optionally) timeout bookkeeping.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        armed_d = 1'b1;
`ifdef MATMUL_LOADER_TIMEOUT_EN
        tmo_d   = tmo_q;
        err_d   = err_q;
`endif
        case (state_q)
            LOAD: begin
                if (accept) begin
                    // cnt[2] picks the matrix, cnt[1] the row, cnt[0] the column.
                    if (cnt_q[2]) begin
                        y_d[cnt_q[1]][cnt_q[0]] = in_data;
                    end else begin
                        x_d[cnt_q[1]][cnt_q[0]] = in_data;
                    end
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        state_d = RUN;
`ifdef MATMUL_LOADER_TIMEOUT_EN
                        tmo_d   = '0;
`endif
                    end
                end
            end
            RUN: begin
                if (mul_done) begin
                    state_d = RESULT;
                end
`ifdef MATMUL_LOADER_TIMEOUT_EN
                else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    // This RUN cycle is the last one allowed: abandon the job.
                    state_d = LOAD;
                    err_d   = 1'b1;
                end
                tmo_d = tmo_q + TMO_W'(1);
`endif
            end
            RESULT: begin
                if (res_ready) begin
                    state_d = LOAD;
                end
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

    // State and operand registers; reset discards any partial load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOAD;
            cnt_q   <= 3'd0;
            x_q     <= '0;
            y_q     <= '0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            armed_q <= armed_d;
        end
    end

`ifdef MATMUL_LOADER_TIMEOUT_EN
    // RUN-cycle counter and sticky timeout flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign x_out = x_q;
    assign y_out = y_q;

endmodule

// File: tb/tb_matmul_operand_loader.sv
// Directed testbench for matmul_operand_loader with a behavioural model of
// the multiplier's done flag (registered one edge after its rst falls).
module tb_matmul_operand_loader;

    localparam int DATA_W = 32;

    logic                           clk;
    logic                           rst_n;
    logic [DATA_W-1:0]              in_data;
    logic                           in_valid;
    logic                           in_ready;
    logic [0:1][0:1][DATA_W-1:0]    x_out;
    logic [0:1][0:1][DATA_W-1:0]    y_out;
    logic                           mul_rst;
    logic                           mul_done;
    logic                           res_valid;
    logic                           res_ready;
    logic                           busy;
    logic                           err;

    logic                           done_en;
    int                             tests;
    int                             fails;

    matmul_operand_loader #(
        .DATA_W         (DATA_W),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_out     (x_out),
        .y_out     (y_out),
        .mul_rst   (mul_rst),
        .mul_done  (mul_done),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .busy      (busy),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier done model: cleared while held in reset, set one edge later.
    always @(posedge clk) begin
        mul_done <= done_en && !mul_rst;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one word and return just after the edge on which it is accepted.
    task automatic send_word(input logic [DATA_W-1:0] d);
        bit done;
        done     = 1'b0;
        in_data  = d;
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            if (in_ready) done = 1'b1;
            step();
        end
        in_valid = 1'b0;
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL send_word_timeout: word %0d not accepted within 50 cycles", d);
        end
    endtask

    function automatic logic [127:0] pack4(input int a, input int b, input int c, input int d);
        return {a[31:0], b[31:0], c[31:0], d[31:0]};
    endfunction

    function automatic int prod00();
        return int'(x_out[0][0]) * int'(y_out[0][0]) + int'(x_out[0][1]) * int'(y_out[1][0]);
    endfunction

    function automatic int prod01();
        return int'(x_out[0][0]) * int'(y_out[0][1]) + int'(x_out[0][1]) * int'(y_out[1][1]);
    endfunction

    initial begin
        tests     = 0;
        fails     = 0;
        done_en   = 1'b1;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        res_ready = 1'b0;
        mul_done  = 1'b0;

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        #2;
        check("rst_in_ready",  128'(in_ready),  128'(0));
        check("rst_mul_rst",   128'(mul_rst),   128'(1));
        check("rst_res_valid", 128'(res_valid), 128'(0));
        check("rst_busy",      128'(busy),      128'(0));
        check("rst_err",       128'(err),       128'(0));
        check("rst_x",         x_out,           128'(0));
        check("rst_y",         y_out,           128'(0));
        rst_n = 1'b1;
        #1;
        check("first_cycle_in_ready", 128'(in_ready), 128'(0));
        step();
        check("armed_in_ready", 128'(in_ready), 128'(1));
        $display("[TB] reset checks done");

        // ---------------- basic job ----------------
        res_ready = 1'b1;
        for (int i = 1; i <= 8; i++) send_word(DATA_W'(i));
        check("basic_x", x_out, pack4(1, 2, 3, 4));
        check("basic_y", y_out, pack4(5, 6, 7, 8));
        check("basic_run_mul_rst",  128'(mul_rst),   128'(0));
        check("basic_run_in_ready", 128'(in_ready),  128'(0));
        check("basic_run_busy",     128'(busy),      128'(1));
        check("basic_out00", 128'(prod00()), 128'(19));
        check("basic_out01", 128'(prod01()), 128'(22));
        step();
        check("basic_run2_res_valid", 128'(res_valid), 128'(0));
        step();
        check("basic_result_res_valid", 128'(res_valid), 128'(1));
        check("basic_result_mul_rst",   128'(mul_rst),   128'(0));
        step();
        check("basic_load_mul_rst",   128'(mul_rst),   128'(1));
        check("basic_load_res_valid", 128'(res_valid), 128'(0));
        check("basic_load_busy",      128'(busy),      128'(0));
        $display("[TB] basic job done");

        // ---------------- gapped stream + backpressure ----------------
        res_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b0;
            in_data  = 32'hDEAD_0000 + 32'(i);
            step();
            step();
            send_word(DATA_W'(10 + i));
            if (i == 4) begin
                // Y slots beyond the fill point still hold the previous job.
                check("gap_partial_x", x_out, pack4(10, 11, 12, 13));
                check("gap_partial_y", y_out, pack4(14, 6, 7, 8));
                check("gap_partial_busy", 128'(busy), 128'(1));
            end
            if (i == 6) begin
                check("gap_7_in_ready", 128'(in_ready), 128'(1));
                check("gap_7_mul_rst",  128'(mul_rst),  128'(1));
            end
        end
        check("gap_run_in_ready", 128'(in_ready), 128'(0));
        check("gap_run_mul_rst",  128'(mul_rst),  128'(0));
        step();
        step();
        for (int c = 0; c < 10; c++) begin
            check("bp_res_valid", 128'(res_valid), 128'(1));
            check("bp_in_ready",  128'(in_ready),  128'(0));
            check("bp_x",         x_out,           pack4(10, 11, 12, 13));
            check("bp_y",         y_out,           pack4(14, 15, 16, 17));
            in_valid = 1'b1;
            in_data  = 32'h0000_BEEF;
            step();
        end
        in_valid  = 1'b0;
        res_ready = 1'b1;
        step();
        check("bp_load_in_ready", 128'(in_ready),  128'(1));
        check("bp_load_res_valid", 128'(res_valid), 128'(0));
        check("bp_load_mul_rst",  128'(mul_rst),   128'(1));
        $display("[TB] gapped stream and backpressure done");

        // ---------------- reset mid-load ----------------
        for (int i = 0; i < 5; i++) send_word(DATA_W'(21 + i));
        check("midload_busy", 128'(busy), 128'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_x",        x_out,           128'(0));
        check("midrst_y",        y_out,           128'(0));
        check("midrst_in_ready", 128'(in_ready),  128'(0));
        check("midrst_mul_rst",  128'(mul_rst),   128'(1));
        check("midrst_busy",     128'(busy),      128'(0));
        step();
        rst_n = 1'b1;
        step();
        for (int i = 0; i < 8; i++) send_word(DATA_W'(31 + i));
        check("reload_x", x_out, pack4(31, 32, 33, 34));
        check("reload_y", y_out, pack4(35, 36, 37, 38));
        step();
        step();
        check("reload_res_valid", 128'(res_valid), 128'(1));
        step();
        $display("[TB] reset mid-load done");

        // ---------------- back-to-back jobs ----------------
        for (int i = 1; i <= 8; i++) send_word(DATA_W'(i));
        in_data  = 32'd41;
        in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            check("b2b_hold_in_ready", 128'(in_ready), 128'(0));
            check("b2b_hold_x",        x_out,          pack4(1, 2, 3, 4));
            step();
        end
        check("b2b_load_in_ready", 128'(in_ready), 128'(1));
        for (int i = 0; i < 8; i++) send_word(DATA_W'(41 + i));
        check("b2b_x", x_out, pack4(41, 42, 43, 44));
        check("b2b_y", y_out, pack4(45, 46, 47, 48));
        check("b2b_out00", 128'(prod00()), 128'(3819));
        step();
        step();
        check("b2b_res_valid", 128'(res_valid), 128'(1));
        step();
        $display("[TB] back-to-back jobs done");

`ifdef MATMUL_LOADER_TIMEOUT_EN
        // ---------------- timeout ----------------
        done_en = 1'b0;
        for (int i = 0; i < 8; i++) send_word(DATA_W'(51 + i));
        for (int c = 0; c < 15; c++) begin
            check("tmo_run_err",       128'(err),       128'(0));
            check("tmo_run_res_valid", 128'(res_valid), 128'(0));
            step();
        end
        check("tmo_last_run_in_ready", 128'(in_ready), 128'(0));
        step();
        check("tmo_err",       128'(err),       128'(1));
        check("tmo_in_ready",  128'(in_ready),  128'(1));
        check("tmo_mul_rst",   128'(mul_rst),   128'(1));
        check("tmo_res_valid", 128'(res_valid), 128'(0));
        repeat (3) step();
        check("tmo_err_sticky", 128'(err), 128'(1));
        rst_n = 1'b0;
        #1;
        check("tmo_err_cleared", 128'(err), 128'(0));
        rst_n = 1'b1;
        $display("[TB] timeout done");
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
